// File: rtl/mem_responder_pkg.sv
// mem_responder_pkg: shared bus codes, widths and FSM state encodings for the memory responder
package mem_responder_pkg;
    localparam int IOSTATEWIDTH = 2;
    localparam int ADDRWIDTH = 16;
    localparam int WORDWIDTH = 16;
    localparam logic [IOSTATEWIDTH-1:0] IDEL = 2'd0;
    localparam logic [IOSTATEWIDTH-1:0] RD = 2'd1;
    localparam logic [IOSTATEWIDTH-1:0] WT = 2'd2;
    typedef enum logic [1:0] {MR_IDLE = 2'd0, MR_BUSY = 2'd1, MR_DONE = 2'd2} mr_state_e;
    typedef struct packed {
        logic id;
        logic [IOSTATEWIDTH-1:0] rw;
        logic [ADDRWIDTH-1:0] addr;
        logic [WORDWIDTH-1:0] data;
    } mr_req_t;
    function automatic logic rw_active(input logic [IOSTATEWIDTH-1:0] rw);
        return rw == RD || rw == WT;
    endfunction
endpackage

// File: rtl/mem_responder_if.sv
// mem_responder_if: cache-to-memory bus for both cache ports; errToCache* exist only with MEM_RANGE_CHECK_EN
interface mem_responder_if;
    import mem_responder_pkg::*;
    logic [IOSTATEWIDTH-1:0] rwFromCache0, rwFromCache1;
    logic [ADDRWIDTH-1:0] addrFromCache0, addrFromCache1;
    logic [WORDWIDTH-1:0] dataFromCache0, dataFromCache1;
    logic [WORDWIDTH-1:0] dataToCache0, dataToCache1;
    logic readEnToCache0, readEnToCache1;
    logic writeDoneToCache0, writeDoneToCache1;
`ifdef MEM_RANGE_CHECK_EN
    logic errToCache0, errToCache1;
`endif
    modport master (
        output rwFromCache0, rwFromCache1, addrFromCache0, addrFromCache1, dataFromCache0, dataFromCache1,
        input dataToCache0, dataToCache1, readEnToCache0, readEnToCache1, writeDoneToCache0, writeDoneToCache1
`ifdef MEM_RANGE_CHECK_EN
        , input errToCache0, errToCache1
`endif
    );
    modport slave (
        input rwFromCache0, rwFromCache1, addrFromCache0, addrFromCache1, dataFromCache0, dataFromCache1,
        output dataToCache0, dataToCache1, readEnToCache0, readEnToCache1, writeDoneToCache0, writeDoneToCache1
`ifdef MEM_RANGE_CHECK_EN
        , output errToCache0, errToCache1
`endif
    );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter with per-port rearm flags
module mem_arbiter
    import mem_responder_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic [IOSTATEWIDTH-1:0] rw0,
    input  logic [IOSTATEWIDTH-1:0] rw1,
    input  logic done,
    input  logic done_id,
    output logic gnt_valid,
    output logic gnt_id
);
    logic prio;
    logic [1:0] rearm;
    logic [1:0] elig;
    always_comb begin
        elig = {rw_active(rw1) & rearm[1], rw_active(rw0) & rearm[0]};
        gnt_valid = |elig;
        gnt_id = &elig ? prio : elig[1];
    end
    // completion disarms a port; an idle sample rearms it, but never in the completing cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prio <= 1'b0;
            rearm <= 2'b11;
        end else begin
            if (done) prio <= ~done_id;
            rearm[0] <= (done && !done_id) ? 1'b0 : (!rw_active(rw0) | rearm[0]);
            rearm[1] <= (done && done_id) ? 1'b0 : (!rw_active(rw1) | rearm[1]);
        end
    end
endmodule

// File: rtl/mem_responder.sv
// mem_responder: two-port shared memory with round-robin service and fixed access latency
// MEM_RANGE_CHECK_EN: addresses >= DEPTH complete with an error pulse instead of wrapping
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int LATENCY = 4
) (
    input logic clk,
    input logic reset,
    mem_responder_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int CW = $clog2(LATENCY + 1);
    mr_state_e state, next;
    mr_req_t req, gnt_req;
    logic [CW-1:0] cnt;
    logic [WORDWIDTH-1:0] mem [DEPTH];
    logic [WORDWIDTH-1:0] rdata, hold0, hold1;
    logic gnt_valid, gnt_id, grant, done, hit, rd_en0, rd_en1;
    logic [IW-1:0] idx;

    mem_arbiter u_arb (
        .clk(clk),
        .reset(reset),
        .rw0(bus.rwFromCache0),
        .rw1(bus.rwFromCache1),
        .done(done),
        .done_id(req.id),
        .gnt_valid(gnt_valid),
        .gnt_id(gnt_id)
    );

    assign gnt_req = gnt_id ? mr_req_t'{1'b1, bus.rwFromCache1, bus.addrFromCache1, bus.dataFromCache1}
                            : mr_req_t'{1'b0, bus.rwFromCache0, bus.addrFromCache0, bus.dataFromCache0};
    assign grant = state == MR_IDLE && gnt_valid;
    assign done = state == MR_DONE;
    assign idx = req.addr[IW-1:0];
`ifdef MEM_RANGE_CHECK_EN
    assign hit = 32'(req.addr) < DEPTH;
    assign bus.errToCache0 = done && !hit && !req.id;
    assign bus.errToCache1 = done && !hit && req.id;
`else
    logic unused_addr_hi;
    assign unused_addr_hi = ^req.addr[ADDRWIDTH-1:IW];
    assign hit = 1'b1;
`endif
    assign rd_en0 = done && hit && req.rw == RD && !req.id;
    assign rd_en1 = done && hit && req.rw == RD && req.id;
    assign bus.readEnToCache0 = rd_en0;
    assign bus.readEnToCache1 = rd_en1;
    assign bus.writeDoneToCache0 = done && hit && req.rw == WT && !req.id;
    assign bus.writeDoneToCache1 = done && hit && req.rw == WT && req.id;
    // read word is live during the pulse, then parked per port until that port's next read
    assign bus.dataToCache0 = rd_en0 ? rdata : hold0;
    assign bus.dataToCache1 = rd_en1 ? rdata : hold1;

    always_comb begin
        next = state;
        if (state == MR_IDLE) next = gnt_valid ? (LATENCY == 1 ? MR_DONE : MR_BUSY) : MR_IDLE;
        else if (state == MR_BUSY) next = cnt == CW'(1) ? MR_DONE : MR_BUSY;
        else next = MR_IDLE;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= MR_IDLE;
            req <= '0;
            cnt <= '0;
            rdata <= '0;
            hold0 <= '0;
            hold1 <= '0;
        end else begin
            state <= next;
            if (grant) begin
                req <= gnt_req;
                cnt <= CW'(LATENCY - 1);
                rdata <= mem[gnt_req.addr[IW-1:0]];
            end else if (state == MR_BUSY) cnt <= cnt - CW'(1);
            if (rd_en0) hold0 <= rdata;
            if (rd_en1) hold1 <= rdata;
        end
    end

    always_ff @(posedge clk) if (done && hit && req.rw == WT) mem[idx] <= req.data;
endmodule

// File: tb/tb_mem_responder.sv
// tb_mem_responder: randomized two-port traffic against a transaction-level memory model
module tb_mem_responder;
    import mem_responder_pkg::*;
    localparam int DEPTH = 256;
    localparam int LATENCY = 4;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;
    mem_responder_if bus();
    mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
    logic err0, err1;
`ifdef MEM_RANGE_CHECK_EN
    assign err0 = bus.errToCache0;
    assign err1 = bus.errToCache1;
`else
    assign err0 = 1'b0;
    assign err1 = 1'b0;
`endif
    int total = 0;
    int bad = 0;
    logic [WORDWIDTH-1:0] ref_mem [DEPTH];
    bit known [DEPTH];
    bit prio_m = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int p, input logic [1:0] rw, input logic [15:0] a, input logic [15:0] d);
        if (p == 0) begin
            bus.rwFromCache0 = rw; bus.addrFromCache0 = a; bus.dataFromCache0 = d;
        end else begin
            bus.rwFromCache1 = rw; bus.addrFromCache1 = a; bus.dataFromCache1 = d;
        end
    endtask

    // 0 none, 1 read, 2 write, 3 error, 7 several at once
    function automatic int kind(input int p);
        logic [2:0] v;
        v = p == 0 ? {bus.readEnToCache0, bus.writeDoneToCache0, err0} : {bus.readEnToCache1, bus.writeDoneToCache1, err1};
        return $countones(v) > 1 ? 7 : v[2] ? 1 : v[1] ? 2 : v[0] ? 3 : 0;
    endfunction

    function automatic logic [15:0] data_of(input int p);
        return p == 0 ? bus.dataToCache0 : bus.dataToCache1;
    endfunction

    function automatic int exp_kind(input logic [1:0] rw, input logic [15:0] a);
`ifdef MEM_RANGE_CHECK_EN
        if (int'(a) >= DEPTH) return 3;
`endif
        return rw == RD ? 1 : 2;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        drive(0, IDEL, 16'h0, 16'h0);
        drive(1, IDEL, 16'h0, 16'h0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        prio_m = 1'b0;
    endtask

    // one service round: both ports driven together, wd withdraws the request after grant
    task automatic run(input logic [1:0] rw0, input logic [15:0] a0, input logic [15:0] d0,
                       input logic [1:0] rw1, input logic [15:0] a1, input logic [15:0] d1, input bit wd);
        logic [1:0] rw [2];
        logic [15:0] a [2];
        logic [15:0] d [2];
        logic [15:0] got_d [2];
        int got_k [2];
        int got_kind [2];
        int exp_k [2];
        bit act [2];
        int order [$];
        int span;
        rw = '{rw0, rw1}; a = '{a0, a1}; d = '{d0, d1};
        for (int p = 0; p < 2; p++) begin
            act[p] = rw_active(rw[p]);
            got_k[p] = 0; got_kind[p] = 0; got_d[p] = '0; exp_k[p] = 0;
        end
        if (act[0] && act[1]) order = '{int'(prio_m), int'(!prio_m)};
        else if (act[0]) order = '{0};
        else if (act[1]) order = '{1};
        if (order.size() > 0) exp_k[order[0]] = LATENCY;
        if (order.size() > 1) exp_k[order[1]] = 2 * LATENCY + 1;
        span = order.size() > 1 ? 2 * LATENCY + 3 : LATENCY + 2;
        @(negedge clk);
        drive(0, rw0, a0, d0);
        drive(1, rw1, a1, d1);
        @(posedge clk);
        for (int k = 1; k <= span; k++) begin
            @(negedge clk);
            if (wd && k == 1) for (int p = 0; p < 2; p++) drive(p, IDEL, a[p], d[p]);
            for (int p = 0; p < 2; p++) begin
                int kd;
                kd = kind(p);
                if (kd != 0) begin
                    check($sformatf("spurious_p%0d", p), 32'(act[p]), 1);
                    check($sformatf("single_pulse_p%0d", p), got_k[p], 0);
                    if (got_k[p] == 0) begin
                        got_k[p] = k; got_kind[p] = kd; got_d[p] = data_of(p);
                    end
                    drive(p, IDEL, a[p], d[p]);
                end
            end
        end
        drive(0, IDEL, a0, d0);
        drive(1, IDEL, a1, d1);
        repeat (2) @(negedge clk);
        foreach (order[i]) begin
            int p, ek, ix;
            p = order[i];
            ek = exp_kind(rw[p], a[p]);
            ix = int'(a[p]) % DEPTH;
            check($sformatf("latency_p%0d", p), got_k[p], exp_k[p]);
            check($sformatf("kind_p%0d", p), got_kind[p], ek);
            if (ek == 1 && known[ix]) check($sformatf("rdata_p%0d_a%0h", p, a[p]), got_d[p], ref_mem[ix]);
            if (ek == 2) begin
                ref_mem[ix] = d[p];
                known[ix] = 1'b1;
            end
        end
        if (order.size() > 0) prio_m = !order[order.size() - 1];
    endtask

    task automatic held_test();
        int n;
        n = 0;
        @(negedge clk);
        drive(1, RD, 16'h03, 16'h0);
        @(posedge clk);
        for (int k = 1; k <= LATENCY + 20; k++) begin
            @(negedge clk);
            if (kind(1) == 1) begin
                n++;
                if (known[3]) check("held_rdata", data_of(1), ref_mem[3]);
            end
        end
        check("held_pulses", n, 1);
        drive(1, IDEL, 16'h03, 16'h0);
        @(negedge clk);
        drive(1, RD, 16'h03, 16'h0);
        n = 0;
        for (int k = 1; k <= LATENCY + 3; k++) begin
            @(negedge clk);
            if (kind(1) == 1) n++;
        end
        check("rearmed_pulses", n, 1);
        drive(1, IDEL, 16'h03, 16'h0);
        repeat (2) @(negedge clk);
        prio_m = 1'b0;
    endtask

    task automatic reset_mid_write();
        @(negedge clk);
        drive(0, WT, 16'h30, 16'hFFFF);
        @(posedge clk);
        for (int k = 1; k < LATENCY; k++) begin
            @(negedge clk);
            check("mid_write_early", kind(0), 0);
        end
        reset = 1'b0;
        drive(0, IDEL, 16'h30, 16'hFFFF);
        repeat (LATENCY + 1) begin
            @(negedge clk);
            check("mid_write_no_pulse", kind(0), 0);
        end
        reset = 1'b1;
        prio_m = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        drive(0, IDEL, 16'h0, 16'h0);
        drive(1, IDEL, 16'h0, 16'h0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rst_kind0", kind(0), 0);
        check("rst_kind1", kind(1), 0);
        check("rst_data0", bus.dataToCache0, 0);
        check("rst_data1", bus.dataToCache1, 0);
        run(WT, 16'h10, 16'hA5A5, IDEL, 16'h0, 16'h0, 1'b0);
        run(RD, 16'h10, 16'h0, IDEL, 16'h0, 16'h0, 1'b0);
        check("wr_then_rd", bus.dataToCache0, 16'hA5A5);
        do_reset();
        run(RD, 16'h01, 16'h0, RD, 16'h02, 16'h0, 1'b0);
        run(WT, 16'h03, 16'h5A5A, IDEL, 16'h0, 16'h0, 1'b0);
        held_test();
        run(WT, 16'h20, 16'h1234, IDEL, 16'h0, 16'h0, 1'b1);
        run(RD, 16'h20, 16'h0, IDEL, 16'h0, 16'h0, 1'b0);
        run(WT, 16'h30, 16'h5555, IDEL, 16'h0, 16'h0, 1'b0);
        reset_mid_write();
        run(RD, 16'h30, 16'h0, IDEL, 16'h0, 16'h0, 1'b0);
        run(WT, 16'h00, 16'hBEEF, IDEL, 16'h0, 16'h0, 1'b0);
        run(RD, 16'h100, 16'h0, IDEL, 16'h0, 16'h0, 1'b0);
        run(2'd3, 16'h05, 16'h0, IDEL, 16'h0, 16'h0, 1'b0);
        for (int i = 0; i < 60; i++) begin
            logic [1:0] rw [2];
            logic [15:0] a [2];
            logic [15:0] d [2];
            int mode;
            mode = $urandom_range(0, 3);
            for (int p = 0; p < 2; p++) begin
                rw[p] = $urandom_range(0, 1) ? WT : RD;
                a[p] = $urandom_range(0, 7) == 0 ? 16'($urandom_range(256, 511)) : 16'($urandom_range(0, 15));
                d[p] = 16'($urandom);
            end
            if (mode == 2 && $urandom_range(0, 5) == 0) rw[$urandom_range(0, 1)] = 2'd3;
            if (mode < 2 || mode == 3) rw[mode == 3 ? $urandom_range(0, 1) : mode] = IDEL;
            run(rw[0], a[0], d[0], rw[1], a[1], d[1], mode == 3);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
